// File: rtl/seg_pkg.sv
// Shared constants, digit index type and the one-hot helper for the 7-seg scan driver.
package seg_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int SEG_W      = 7;
    localparam int MAX_DIGITS = 8;

    typedef logic [$clog2(MAX_DIGITS)-1:0] digit_idx_t;

    // Active-high digit enable for the given digit position.
    function automatic logic [MAX_DIGITS-1:0] onehot(input digit_idx_t idx);
        logic [MAX_DIGITS-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display-value input and scanned digit output bundle of the 7-seg scan driver.
interface seg_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value_in;
    logic [DIGITS-1:0]   dp_in;
    logic                load;
    logic                blank_lz;
    logic [3:0]          hex_out;
    logic                blank_out;
    logic                dp_out;
    logic [DIGITS-1:0]   digit_sel;
    logic                frame_start;

    // Producer of the display value; consumes the scanned digit stream.
    modport master (
        output value_in, dp_in, load, blank_lz,
        input  hex_out, blank_out, dp_out, digit_sel, frame_start
    );

    // The scan driver itself.
    modport slave (
        input  value_in, dp_in, load, blank_lz,
        output hex_out, blank_out, dp_out, digit_sel, frame_start
    );
endinterface

// File: rtl/seg_lz_mask.sv
// Leading-zero blank mask: digit i is blanked when blanking is enabled, i is not
// the least significant digit, and nibbles i..DIGITS-1 are all zero.
module seg_lz_mask
    import seg_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [DIGITS*NIBBLE_W-1:0] active_i,
    input  logic                       blank_lz_i,
    output logic [DIGITS-1:0]          mask_o
);

    logic zero_run;

    // Walk from the most significant digit down, tracking an unbroken run of zeros.
    always_comb begin
        zero_run = 1'b1;
        mask_o   = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            zero_run = zero_run && (active_i[(DIGITS-1-k)*NIBBLE_W +: NIBBLE_W] == '0);
            mask_o[DIGITS-1-k] = blank_lz_i && zero_run && (k != DIGITS-1);
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan controller for a multi-digit common-cathode 7-seg display,
// with frame-aligned (tear-free) value update, guard time and leading-zero blanking.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int GUARD    = 1
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_driver_if.slave bus
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [IW-1:0]                   idx_q, idx_d;
    logic [DIGITS-1:0][NIBBLE_W-1:0] active_q, active_d, shadow_q, shadow_d;
    logic [DIGITS-1:0]               act_dp_q, act_dp_d, shd_dp_q, shd_dp_d;
    logic                            pending_q, pending_d;
    logic [3:0]                      hex_q, hex_d;
    logic                            blank_q, blank_d;
    logic                            dp_q, dp_d;
    logic [DIGITS-1:0]               sel_q, sel_d;
    logic                            fs_q, fs_d;
    logic                            wrap;
    logic [DIGITS-1:0]               lz_mask;
    logic [MAX_DIGITS-1:0]           sel_full;

    seg_lz_mask #(.DIGITS(DIGITS)) u_lz_mask (
        .active_i   (active_q),
        .blank_lz_i (bus.blank_lz),
        .mask_o     (lz_mask)
    );

    // Next-state: scan counters, shadow/active transfer at frame wrap, and the
    // output values derived from the current cnt/idx/active.
    always_comb begin
        wrap      = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        shadow_d  = shadow_q;
        shd_dp_d  = shd_dp_q;
        active_d  = active_q;
        act_dp_d  = act_dp_q;
        pending_d = pending_q;
        if (bus.load) begin
            shadow_d  = bus.value_in;
            shd_dp_d  = bus.dp_in;
            pending_d = 1'b1;
        end
        // A load landing on the wrap cycle bypasses the shadow so it is not delayed a frame.
        if (wrap) begin
            if (bus.load) begin
                active_d  = bus.value_in;
                act_dp_d  = bus.dp_in;
                pending_d = 1'b0;
            end else if (pending_q) begin
                active_d  = shadow_q;
                act_dp_d  = shd_dp_q;
                pending_d = 1'b0;
            end
        end

        sel_full = onehot(digit_idx_t'(idx_q));
        sel_d    = (cnt_q < GUARD_C) ? '0 : sel_full[DIGITS-1:0];
        blank_d  = lz_mask[idx_q];
        hex_d    = blank_d ? '0 : active_q[idx_q];
        dp_d     = act_dp_q[idx_q];
        fs_d     = (cnt_q == '0) && (idx_q == '0);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            active_q  <= '0;
            act_dp_q  <= '0;
            shadow_q  <= '0;
            shd_dp_q  <= '0;
            pending_q <= 1'b0;
            hex_q     <= '0;
            blank_q   <= 1'b1;
            dp_q      <= 1'b0;
            sel_q     <= '0;
            fs_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            act_dp_q  <= act_dp_d;
            shadow_q  <= shadow_d;
            shd_dp_q  <= shd_dp_d;
            pending_q <= pending_d;
            hex_q     <= hex_d;
            blank_q   <= blank_d;
            dp_q      <= dp_d;
            sel_q     <= sel_d;
            fs_q      <= fs_d;
        end
    end

    assign bus.hex_out     = hex_q;
    assign bus.blank_out   = blank_q;
    assign bus.dp_out      = dp_q;
    assign bus.digit_sel   = sel_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (DIGITS=4, SCAN_DIV=4, GUARD=1).
module tb_seg_scan_driver;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seg_scan_driver_if #(.DIGITS(4)) bus ();

    seg_scan_driver #(
        .DIGITS   (4),
        .SCAN_DIV (4),
        .GUARD    (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one 16-cycle frame starting at a frame boundary and checks every cycle
    // against the expected displayed value; optional loads at cycles la / lb.
    task automatic run_frame(input string tag,
                             input logic [15:0] exp_hex, input logic [3:0] exp_blank,
                             input logic [3:0] exp_dp,
                             input int la, input logic [15:0] va, input logic [3:0] da,
                             input int lb, input logic [15:0] vb, input logic [3:0] db);
        int d;
        for (int i = 0; i < 16; i++) begin
            bus.load = 1'b0;
            if (i == la) begin bus.value_in = va; bus.dp_in = da; bus.load = 1'b1; end
            if (i == lb) begin bus.value_in = vb; bus.dp_in = db; bus.load = 1'b1; end
            tick();
            d = i / 4;
            check({tag, "_sel"},   32'(bus.digit_sel), (i % 4 == 0) ? 32'd0 : (32'd1 << d));
            check({tag, "_fs"},    32'(bus.frame_start), (i == 0) ? 32'd1 : 32'd0);
            check({tag, "_hex"},   32'(bus.hex_out), 32'(exp_hex[d*4 +: 4]));
            check({tag, "_blank"}, 32'(bus.blank_out), 32'(exp_blank[d]));
            check({tag, "_dp"},    32'(bus.dp_out), 32'(exp_dp[d]));
        end
        bus.load = 1'b0;
    endtask

    initial begin
        int zero_cnt;
        int fs_cnt;
        int last_fs;
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.value_in = '0;
        bus.dp_in    = '0;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b1;

        // Reset values
        tick(); tick(); tick();
        check("rst_sel",   32'(bus.digit_sel), 32'd0);
        check("rst_hex",   32'(bus.hex_out), 32'd0);
        check("rst_dp",    32'(bus.dp_out), 32'd0);
        check("rst_blank", 32'(bus.blank_out), 32'd1);
        check("rst_fs",    32'(bus.frame_start), 32'd0);
        rst = 1'b0;

        // 1: idle scan with zero value, leading zeros blanked
        run_frame("t1", 16'h0000, 4'b1110, 4'b0000, -1, '0, '0, -1, '0, '0);

        // 2: mid-frame load is not visible until the next frame
        run_frame("t2a", 16'h0000, 4'b1110, 4'b0000, 6, 16'h1A3F, 4'b0100, -1, '0, '0);
        run_frame("t2b", 16'h1A3F, 4'b0000, 4'b0100, -1, '0, '0, -1, '0, '0);

        // 3: leading-zero blanking of 0050, then blanking disabled live
        run_frame("t3a", 16'h1A3F, 4'b0000, 4'b0100, 9, 16'h0050, 4'b0000, -1, '0, '0);
        run_frame("t3b", 16'h0050, 4'b1100, 4'b0000, -1, '0, '0, -1, '0, '0);
        bus.blank_lz = 1'b0;
        run_frame("t3c", 16'h0050, 4'b0000, 4'b0000, -1, '0, '0, -1, '0, '0);

        // 4: last of two loads wins; load on the wrap cycle shows next frame
        run_frame("t4a", 16'h0050, 4'b0000, 4'b0000, 3, 16'h1111, 4'b0000, 10, 16'h2222, 4'b0000);
        run_frame("t4b", 16'h2222, 4'b0000, 4'b0000, 15, 16'h4321, 4'b1001, -1, '0, '0);
        run_frame("t4c", 16'h4321, 4'b0000, 4'b1001, -1, '0, '0, -1, '0, '0);

        // 5: reset mid-slot of digit 2 with a pending load
        bus.blank_lz = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.value_in = 16'h9999;
            bus.dp_in    = 4'b1111;
            bus.load     = (i == 1);
            tick();
        end
        bus.load = 1'b0;
        check("t5_pre_sel", 32'(bus.digit_sel), 32'b0100);
        rst = 1'b1;
        tick();
        check("t5_sel",   32'(bus.digit_sel), 32'd0);
        check("t5_hex",   32'(bus.hex_out), 32'd0);
        check("t5_dp",    32'(bus.dp_out), 32'd0);
        check("t5_blank", 32'(bus.blank_out), 32'd1);
        check("t5_fs",    32'(bus.frame_start), 32'd0);
        rst = 1'b0;
        run_frame("t5a", 16'h0000, 4'b1110, 4'b0000, -1, '0, '0, -1, '0, '0);
        run_frame("t5b", 16'h0000, 4'b1110, 4'b0000, -1, '0, '0, -1, '0, '0);

        // 6: one-hot, guard count and frame_start period over 3 frames
        zero_cnt = 0;
        fs_cnt   = 0;
        last_fs  = -1;
        for (int i = 0; i < 48; i++) begin
            tick();
            check("t6_onehot", 32'($countones(bus.digit_sel) <= 1), 32'd1);
            if (bus.digit_sel == '0) zero_cnt++;
            if (bus.frame_start) begin
                if (last_fs >= 0) check("t6_fs_period", 32'(i - last_fs), 32'd16);
                last_fs = i;
                fs_cnt++;
            end
        end
        check("t6_guard_cycles", 32'(zero_cnt), 32'd12);
        check("t6_fs_count",     32'(fs_cnt), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
